// File: rtl/sprite_bram_writer.sv
// Sprite stream to BRAM writer.
// Parses SYNC | addr[3] | len[2] | N x {H,L} | xor-checksum packets from a
// byte stream and writes 12-bit pixels into BRAM port B. Writes happen only
// when the top level grants the port (wr_allow, vertical blanking).
module sprite_bram_writer #(
  parameter int unsigned DEPTH = 76800,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        wr_allow,
  output logic        we,
  output logic [16:0] waddr,
  output logic [11:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  pkt_count
);

  typedef enum logic [2:0] {
    IDLE, HDR, PIX_H, PIX_L, WRITE, CSUM, DISCARD
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  hcnt_q, hcnt_d;    // header byte index 0..4
  logic [16:0] start_q, start_d;  // first pixel address
  logic [15:0] len_q, len_d;      // pixel count N
  logic [7:0]  h_q, h_d;          // full H byte, needed for the checksum
  logic [7:0]  gb_q, gb_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] pix_q, pix_d;      // 0-based index of the pixel being built
  logic [16:0] dcnt_q, dcnt_d;    // bytes left to drop in DISCARD, minus one
  logic        we_q, we_d;
  logic [16:0] waddr_q, waddr_d;
  logic [11:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  pkt_q, pkt_d;

  logic        acc;
  logic [15:0] n_full;
  logic [17:0] end_addr;

  assign in_ready  = (state_q != WRITE);
  assign busy      = (state_q != IDLE);
  assign acc       = in_valid & in_ready;
  // Length as it will be once the 5th header byte lands; end checked in 18 bits
  // so a start near the top plus a large N cannot wrap and slip through.
  assign n_full    = {len_q[15:8], in_data};
  assign end_addr  = {1'b0, start_q} + {2'b00, n_full};

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign pkt_count = pkt_q;

  // Next-state and datapath update; pulses default low, everything else holds.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    start_d = start_q;
    len_d   = len_q;
    h_d     = h_q;
    gb_d    = gb_q;
    csum_d  = csum_q;
    pix_d   = pix_q;
    dcnt_d  = dcnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    pkt_d   = pkt_q;
    case (state_q)
      IDLE: begin
        if (acc && in_data == SYNC) begin
          state_d = HDR;
          hcnt_d  = 3'd0;
          csum_d  = 8'h00;
          pix_d   = 16'd0;
        end
      end
      HDR: begin
        if (acc) begin
          hcnt_d = hcnt_q + 3'd1;
          case (hcnt_q)
            3'd0:    start_d[16]   = in_data[0];
            3'd1:    start_d[15:8] = in_data;
            3'd2:    start_d[7:0]  = in_data;
            3'd3:    len_d[15:8]   = in_data;
            default: begin
              len_d[7:0] = in_data;
              if (end_addr > 18'(DEPTH)) begin
                state_d = DISCARD;
                dcnt_d  = {n_full, 1'b0};
              end else if (n_full == 16'd0) begin
                state_d = CSUM;
              end else begin
                state_d = PIX_H;
              end
            end
          endcase
        end
      end
      PIX_H: begin
        if (acc) begin
          h_d     = in_data;
          state_d = PIX_L;
        end
      end
      PIX_L: begin
        if (acc) begin
          gb_d    = in_data;
          csum_d  = csum_q ^ h_q ^ in_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (wr_allow) begin
          we_d    = 1'b1;
          waddr_d = start_q + 17'(pix_q);
          wdata_d = {h_q[3:0], gb_q};
          pix_d   = pix_q + 16'd1;
          state_d = (pix_q == len_q - 16'd1) ? CSUM : PIX_H;
        end
      end
      CSUM: begin
        if (acc) begin
          if (in_data == csum_q) begin
            done_d = 1'b1;
            pkt_d  = pkt_q + 8'd1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (acc) begin
          if (dcnt_q == 17'd0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            dcnt_d  = dcnt_q - 17'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q  <= '0;
      start_q <= '0;
      len_q   <= '0;
      h_q     <= '0;
      gb_q    <= '0;
      csum_q  <= '0;
      pix_q   <= '0;
      dcnt_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pkt_q   <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      start_q <= start_d;
      len_q   <= len_d;
      h_q     <= h_d;
      gb_q    <= gb_d;
      csum_q  <= csum_d;
      pix_q   <= pix_d;
      dcnt_q  <= dcnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pkt_q   <= pkt_d;
    end
  end

endmodule

// File: tb/tb_sprite_bram_writer.sv
// Bench for sprite_bram_writer: directed packet table, hand-written stall and
// reset sequences, then random packets scored against a packet-level model.
module tb_sprite_bram_writer;

  logic        clk, rst, in_valid, in_ready, wr_allow, we, busy, done, err;
  logic [7:0]  in_data, pkt_count;
  logic [16:0] waddr;
  logic [11:0] wdata;

  sprite_bram_writer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_allow(wr_allow), .we(we), .waddr(waddr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0, nmis = 0;
  int done_seen, err_seen;
  logic [28:0] got[$];
  logic [28:0] exp_w[$];
  int md, me;
  int exp_pkt;

  logic rand_on, wa_force, rnd_wa;
  assign wr_allow = rand_on ? rnd_wa : wa_force;
  always @(negedge clk) rnd_wa <= ($urandom_range(0, 3) != 0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Observe write port and status pulses away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (we) got.push_back({waddr, wdata});
      if (done) done_seen++;
      if (err) err_seen++;
      if (done || err) chk("done_err_exclusive", 32'(done & err), 32'd0);
    end
  end

  function automatic logic [28:0] wd(input int a, input int d);
    return {17'(a), 12'(d)};
  endfunction

  // Offer one byte, waiting (bounded) for in_ready; returns at the negedge
  // after the accepting edge.
  task automatic send(input logic [7:0] b);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && g < 2000) begin @(negedge clk); g++; end
    if (g >= 2000) begin
      nvec++; nmis++;
      $display("FAIL send_timeout: in_ready still 0, required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_pkt(input logic [7:0] q[$]);
    got.delete();
    done_seen = 0;
    err_seen  = 0;
    foreach (q[i]) send(q[i]);
    repeat (3) @(negedge clk);
  endtask

  // Packet-level reference: decode fields arithmetically from the byte list.
  task automatic model(input logic [7:0] q[$]);
    int i, st, n;
    logic [7:0] x;
    exp_w.delete();
    md = 0; me = 0;
    i = 0;
    while (i < q.size()) begin
      if (q[i] != 8'hA5) begin i++; continue; end
      if (i + 6 > q.size()) break;
      st = q[i+1][0] * 65536 + q[i+2] * 256 + q[i+3];
      n  = q[i+4] * 256 + q[i+5];
      i += 6;
      if (st + n > 76800) begin
        i += 2 * n + 1;
        me++;
        continue;
      end
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
        exp_w.push_back(wd(st + k, q[i+2*k][3:0] * 256 + q[i+2*k+1]));
        x ^= q[i+2*k] ^ q[i+2*k+1];
      end
      i += 2 * n;
      if (q[i] == x) md++; else me++;
      i++;
    end
  endtask

  typedef struct {
    string        name;
    logic [127:0] b;    // bytes right-aligned, first byte most significant
    int           nb;
    int           nwe, nd, ne, pinc;
    logic [28:0]  w0, w1;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [7:0] q[$];
    logic [7:0] b, x;
    int st, n;

    vt[0] = '{"good_pkt",   128'hA5_00_00_10_00_02_0F_FF_01_23_D2, 11, 2, 1, 0, 1, wd(16, 'hFFF), wd(17, 'h123)};
    vt[1] = '{"csum_00",    128'hA5_00_00_10_00_02_0F_FF_01_23_00, 11, 2, 0, 1, 0, wd(16, 'hFFF), wd(17, 'h123)};
    vt[2] = '{"csum_DF",    128'hA5_00_00_10_00_02_0F_FF_01_23_DF, 11, 2, 0, 1, 0, wd(16, 'hFFF), wd(17, 'h123)};
    vt[3] = '{"discard",    128'hA5_01_2B_FF_00_02_A5_11_22_33_44, 11, 0, 0, 1, 0, 29'd0, 29'd0};
    vt[4] = '{"junk_n0",    128'h00_11_A5_00_00_00_00_00_00,       9, 0, 1, 0, 1, 29'd0, 29'd0};
    vt[5] = '{"fits_edge",  128'hA5_01_2B_FE_00_02_01_02_03_04_04, 11, 2, 1, 0, 1, wd('h12BFE, 'h102), wd('h12BFF, 'h304)};
    vt[6] = '{"sync_data",  128'hA5_00_00_00_00_01_A5_A5_00,       9, 1, 1, 0, 1, wd(0, 'h5A5), wd(0, 'h5A5)};
    vt[7] = '{"addr_upper", 128'hA5_FF_00_05_00_01_3C_21_1D,       9, 1, 1, 0, 1, wd('h10005, 'hC21), wd('h10005, 'hC21)};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    rand_on = 1'b0; wa_force = 1'b1;
    done_seen = 0; err_seen = 0; exp_pkt = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(we), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_err", 32'({done, err}), 0);
    chk("rst_pkt", 32'(pkt_count), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 1);

    // Directed packet table.
    foreach (vt[v]) begin
      q.delete();
      for (int i = 0; i < vt[v].nb; i++) q.push_back(vt[v].b[8*(vt[v].nb-1-i) +: 8]);
      run_pkt(q);
      exp_pkt = (exp_pkt + vt[v].pinc) % 256;
      chk({vt[v].name, "_nwe"}, 32'(got.size()), 32'(vt[v].nwe));
      chk({vt[v].name, "_done"}, 32'(done_seen), 32'(vt[v].nd));
      chk({vt[v].name, "_err"}, 32'(err_seen), 32'(vt[v].ne));
      chk({vt[v].name, "_pkt"}, 32'(pkt_count), 32'(exp_pkt));
      if (vt[v].nwe >= 1 && got.size() >= 1) chk({vt[v].name, "_w0"}, 32'(got[0]), 32'(vt[v].w0));
      if (vt[v].nwe >= 2 && got.size() >= 2) chk({vt[v].name, "_w1"}, 32'(got[got.size()-1]), 32'(vt[v].w1));
      chk({vt[v].name, "_idle"}, 32'(busy), 0);
    end

    // Write port withheld for 20 cycles during the first pixel.
    got.delete(); done_seen = 0; err_seen = 0;
    wa_force = 1'b0;
    q = {8'hA5, 8'h00, 8'h00, 8'h20, 8'h00, 8'h01, 8'h0F, 8'hFF};
    foreach (q[i]) send(q[i]);
    for (int c = 0; c < 20; c++) begin
      chk("stall_ready_we", 32'({in_ready, we}), 0);
      @(negedge clk);
    end
    chk("stall_busy", 32'(busy), 1);
    wa_force = 1'b1;
    @(negedge clk);
    chk("stall_we", 32'(we), 1);
    @(negedge clk);
    chk("stall_we_once", 32'(we), 0);
    chk("stall_nwe", 32'(got.size()), 1);
    if (got.size() >= 1) chk("stall_w", 32'(got[0]), 32'(wd('h20, 'hFFF)));
    send(8'hF0);
    repeat (2) @(negedge clk);
    exp_pkt = (exp_pkt + 1) % 256;
    chk("stall_done", 32'(done_seen), 1);
    chk("stall_pkt", 32'(pkt_count), 32'(exp_pkt));

    // Reset after the first pixel's H byte.
    q = {8'hA5, 8'h00, 8'h00, 8'h10, 8'h00, 8'h02, 8'h0F};
    foreach (q[i]) send(q[i]);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy_we", 32'({busy, we}), 0);
    chk("mid_rst_pkt", 32'(pkt_count), 0);
    chk("mid_rst_addr_data", 32'({waddr, wdata}), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_pkt = 0;
    @(negedge clk);
    q = {8'hA5, 8'h00, 8'h00, 8'h10, 8'h00, 8'h02, 8'h0F, 8'hFF, 8'h01, 8'h23, 8'hD2};
    run_pkt(q);
    exp_pkt = 1;
    chk("post_rst_nwe", 32'(got.size()), 2);
    if (got.size() == 2) begin
      chk("post_rst_w0", 32'(got[0]), 32'(wd(16, 'hFFF)));
      chk("post_rst_w1", 32'(got[1]), 32'(wd(17, 'h123)));
    end
    chk("post_rst_pkt", 32'(pkt_count), 1);

    // pkt_count wrap: 255 more good empty packets.
    q = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int p = 0; p < 254; p++) run_pkt(q);
    chk("pkt_255", 32'(pkt_count), 255);
    run_pkt(q);
    exp_pkt = 0;
    chk("pkt_wrap", 32'(pkt_count), 0);

    // Random packets with a randomly toggling write grant.
    rand_on = 1'b1;
    for (int r = 0; r < 40; r++) begin
      q.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        q.push_back(b);
      end
      q.push_back(8'hA5);
      if ($urandom_range(0, 4) == 0) st = 76800 - $urandom_range(0, 4);
      else st = $urandom_range(0, 76799);
      n = $urandom_range(0, 5);
      q.push_back({7'($urandom), st[16]});
      q.push_back(st[15:8]);
      q.push_back(st[7:0]);
      q.push_back(n[15:8]);
      q.push_back(n[7:0]);
      x = 8'h00;
      if (st + n > 76800) begin
        repeat (2 * n + 1) q.push_back(8'($urandom));
      end else begin
        repeat (2 * n) begin b = 8'($urandom); x ^= b; q.push_back(b); end
        if ($urandom_range(0, 4) == 0) x ^= 8'($urandom_range(1, 255));
        q.push_back(x);
      end
      model(q);
      run_pkt(q);
      exp_pkt = (exp_pkt + md) % 256;
      chk("rnd_nwe", 32'(got.size()), 32'(exp_w.size()));
      if (got.size() == exp_w.size())
        foreach (exp_w[k]) chk("rnd_write", 32'(got[k]), 32'(exp_w[k]));
      chk("rnd_done", 32'(done_seen), 32'(md));
      chk("rnd_err", 32'(err_seen), 32'(me));
      chk("rnd_pkt", 32'(pkt_count), 32'(exp_pkt));
    end
    rand_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
